dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl_pkg.sv | 38 +++
 rtl/dm_ctrl_arb.sv | 28 ++
 rtl/dm_ctrl.sv | 151 +++++++++++++++
 tb/tb_dm_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared op codes, FSM encoding and load-select constants for dm_ctrl
package dm_ctrl_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  localparam logic [3:0] LDSEL_WORD = 4'b0000;
  localparam logic [3:0] LDSEL_LB   = 4'b0001;
  localparam logic [3:0] LDSEL_LBU  = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RMW_WR = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Word ops need natural alignment; byte ops may hit any lane.
  function automatic logic op_legal(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         op_legal = (lo == 2'b00);
      OP_LB, OP_LBU, OP_SB: op_legal = 1'b1;
      default:              op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[8*lane +: 8] = b;
    merge_byte = w;
  endfunction

endpackage

// File: rtl/dm_ctrl_arb.sv
// rtl/dm_ctrl_arb.sv - two-way round-robin grant (rr_arb2) for the dm_ctrl request ports
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Port favoured on the next tie; starts at port 0.
  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          prio_q <= 1'b0;
    else if (advance) prio_q <= gnt[0];
  end

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - two-port data-memory controller with byte-store read-modify-write
module dm_ctrl
  import dm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [8:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [8:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp0_err,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic        rsp1_err,
  output logic [31:0] rsp1_rdata,
  output logic        dm_DMWr,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic [3:0]  dm_LOADSel,
  output logic [1:0]  dm_byte,
  input  logic [31:0] dm_dout
);

  state_e            state_q, state_d;
  logic [1:0]        arb_req, gnt;
  logic              hs, sel;
  logic [2:0]        in_op;
  logic [8:0]        in_addr;
  logic [31:0]       in_wdata;
  logic              port_q;
  logic [2:0]        op_q;
  logic [8:0]        addr_q;
  logic [31:0]       wdata_q, cap_q;
  logic [1:0][31:0]  rsp_rdata_q;
  logic [1:0]        rsp_err_q;

  assign arb_req = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && !rst}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (hs),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign hs         = |gnt;
  assign sel        = gnt[1];
  assign in_op      = sel ? req1_op    : req0_op;
  assign in_addr    = sel ? req1_addr  : req0_addr;
  assign in_wdata   = sel ? req1_wdata : req0_wdata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hs) state_d = op_legal(in_op, in_addr[1:0]) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_d = (op_q == OP_SB) ? ST_RMW_WR : ST_RESP;
      ST_RMW_WR: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response registers change only on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q      <= 1'b0;
      op_q        <= 3'b000;
      addr_q      <= 9'd0;
      wdata_q     <= 32'd0;
      cap_q       <= 32'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      if (hs) begin
        port_q  <= sel;
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        if (!op_legal(in_op, in_addr[1:0])) begin
          rsp_err_q[sel]   <= 1'b1;
          rsp_rdata_q[sel] <= 32'd0;
        end
      end
      if (state_q == ST_ACCESS) begin
        if (op_q == OP_SB) begin
          cap_q <= dm_dout;
        end else begin
          rsp_err_q[port_q]   <= 1'b0;
          rsp_rdata_q[port_q] <= (op_q == OP_SW) ? 32'd0 : dm_dout;
        end
      end
      if (state_q == ST_RMW_WR) begin
        rsp_err_q[port_q]   <= 1'b0;
        rsp_rdata_q[port_q] <= 32'd0;
      end
    end
  end

  always_comb begin
    dm_DMWr    = 1'b0;
    dm_addr    = 7'd0;
    dm_din     = 32'd0;
    dm_LOADSel = LDSEL_WORD;
    dm_byte    = 2'b00;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        dm_addr = addr_q[8:2];
        dm_byte = addr_q[1:0];
        if (op_q == OP_LB)  dm_LOADSel = LDSEL_LB;
        if (op_q == OP_LBU) dm_LOADSel = LDSEL_LBU;
        if (op_q == OP_SW) begin
          dm_DMWr = 1'b1;
          dm_din  = wdata_q;
        end
      end
      ST_RMW_WR: begin
        dm_addr = addr_q[8:2];
        dm_byte = addr_q[1:0];
        dm_DMWr = 1'b1;
        dm_din  = merge_byte(cap_q, addr_q[1:0], wdata_q[7:0]);
      end
      ST_RESP: begin
        rsp0_valid = !port_q;
        rsp1_valid = port_q;
      end
      default: ;
    endcase
  end

  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - self-checking bench for dm_ctrl
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [8:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        dm_DMWr;
  logic [6:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic [3:0]  dm_LOADSel;
  logic [1:0]  dm_byte;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [128];
  logic [31:0] mw;
  logic [7:0]  mb;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err), .rsp1_rdata(rsp1_rdata),
    .dm_DMWr(dm_DMWr), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_LOADSel(dm_LOADSel), .dm_byte(dm_byte), .dm_dout(dm_dout)
  );

  // Memory model: the memory itself extracts/extends bytes according to LOADSel.
  always_comb begin
    mw = mem[dm_addr];
    mb = mw[8*dm_byte +: 8];
    case (dm_LOADSel)
      4'b0001: dm_dout = {{24{mb[7]}}, mb};
      4'b0010: dm_dout = {24'd0, mb};
      default: dm_dout = mw;
    endcase
  end

  always @(posedge clk) if (dm_DMWr) mem[dm_addr] <= dm_din;

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wr_cyc;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic [2:0] op, input logic [8:0] a,
                              input logic [31:0] d, input logic e, input logic [31:0] rd,
                              input int lat, input int wc, input logic [31:0] din);
    vec_t v;
    v.port = p; v.op = op; v.addr = a; v.wdata = d; v.err = e; v.rdata = rd;
    v.lat = lat; v.wr_cyc = wc; v.din = din;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic v, input logic [2:0] op,
                       input logic [8:0] a, input logic [31:0] d);
    if (!p) begin
      req0_valid = v; req0_op = op; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_op = op; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, lat, wr_n, wr_c, wrong;
    logic [31:0] rd, din;
    logic er;
    logic [6:0] wa;
    lat = 0; wr_n = 0; wr_c = 0; wrong = 0; rd = 'x; er = 'x; din = 'x; wa = 'x;
    @(negedge clk);
    drive(v.port, 1'b1, v.op, v.addr, v.wdata);
    #1;
    n = 0;
    while (!(v.port ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d granted", idx), {31'd0, n < 10}, 32'd1);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 3'b000, 9'd0, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (dm_DMWr) begin wr_n++; wr_c = c; din = dm_din; wa = dm_addr; end
      if ((v.port ? rsp1_valid : rsp0_valid) && lat == 0) begin
        lat = c;
        rd = v.port ? rsp1_rdata : rsp0_rdata;
        er = v.port ? rsp1_err : rsp0_err;
      end
      if (v.port ? rsp0_valid : rsp1_valid) wrong++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.err});
    chk($sformatf("v%0d rdata", idx), rd, v.rdata);
    chk($sformatf("v%0d other_port_rsp", idx), wrong, 0);
    chk($sformatf("v%0d write_count", idx), wr_n, (v.wr_cyc != 0) ? 1 : 0);
    if (v.wr_cyc != 0) begin
      chk($sformatf("v%0d write_cycle", idx), wr_c, v.wr_cyc);
      chk($sformatf("v%0d write_din", idx), din, v.din);
      chk($sformatf("v%0d write_addr", idx), {25'd0, wa}, {25'd0, v.addr[8:2]});
    end
  endtask

  int order[$];
  int bad_both, dmwr_seen;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[4] = 32'h11112222;
    mem[5] = 32'h33334444;
    rst = 1'b1;
    drive(1'b0, 1'b1, OP_LW, 9'h010, 32'd0);
    drive(1'b1, 1'b1, OP_LW, 9'h014, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst rsp0_rdata", rsp0_rdata, 32'd0);
    chk("rst rsp_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
    chk("rst dm_outputs", {dm_DMWr, dm_addr, dm_LOADSel, dm_byte} | dm_din, 32'd0);

    // Both ports requesting continuously from reset: grants must alternate starting at 0.
    rst = 1'b0;
    #1;
    chk("rr first ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    bad_both = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp0_valid && rsp1_valid) bad_both++;
      if (rsp0_valid) begin order.push_back(0); chk("rr rsp0_rdata", rsp0_rdata, 32'h11112222); end
      if (rsp1_valid) begin order.push_back(1); chk("rr rsp1_rdata", rsp1_rdata, 32'h33334444); end
    end
    chk("rr both_valid", bad_both, 0);
    chk("rr rsp_count", {31'd0, order.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < order.size(); i++)
      chk($sformatf("rr order%0d", i), order[i], i % 2);
    drive(1'b0, 1'b0, OP_LW, 9'd0, 32'd0);
    drive(1'b1, 1'b0, OP_LW, 9'd0, 32'd0);
    repeat (5) @(negedge clk);

    vecs.push_back(mk(0, OP_SW,  9'h010, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, OP_LW,  9'h010, 32'h0,        0, 32'hDEADBEEF, 2, 0, 32'h0));
    vecs.push_back(mk(0, OP_SW,  9'h010, 32'h80F1E2D3, 0, 32'h0,        2, 1, 32'h80F1E2D3));
    vecs.push_back(mk(1, OP_LB,  9'h013, 32'h0,        0, 32'hFFFFFF80, 2, 0, 32'h0));
    vecs.push_back(mk(1, OP_LBU, 9'h013, 32'h0,        0, 32'h00000080, 2, 0, 32'h0));
    vecs.push_back(mk(1, OP_LW,  9'h010, 32'h0,        0, 32'h80F1E2D3, 2, 0, 32'h0));
    vecs.push_back(mk(0, OP_SB,  9'h011, 32'h00000055, 0, 32'h0,        3, 2, 32'h80F155D3));
    vecs.push_back(mk(0, OP_LW,  9'h010, 32'h0,        0, 32'h80F155D3, 2, 0, 32'h0));
    vecs.push_back(mk(1, OP_LB,  9'h010, 32'h0,        0, 32'hFFFFFFD3, 2, 0, 32'h0));
    vecs.push_back(mk(1, OP_LBU, 9'h011, 32'h0,        0, 32'h00000055, 2, 0, 32'h0));
    vecs.push_back(mk(0, OP_LW,  9'h012, 32'h0,        1, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 3'b011, 9'h010, 32'h0,        1, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, OP_SW,  9'h013, 32'h12345678, 1, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 3'b111, 9'h010, 32'h0,        1, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, OP_SB,  9'h012, 32'hAAAAAA11, 0, 32'h0,        3, 2, 32'h801155D3));
    vecs.push_back(mk(0, OP_LB,  9'h012, 32'h0,        0, 32'h00000011, 2, 0, 32'h0));
    vecs.push_back(mk(1, OP_SB,  9'h017, 32'h000000FF, 0, 32'h0,        3, 2, 32'hFF334444));
    vecs.push_back(mk(1, OP_LW,  9'h014, 32'h0,        0, 32'hFF334444, 2, 0, 32'h0));
    vecs.push_back(mk(0, OP_LW,  9'h010, 32'h0,        0, 32'h801155D3, 2, 0, 32'h0));
    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("hold rsp1_rdata", rsp1_rdata, 32'hFF334444);

    // Reset during the ACCESS cycle of a byte store aborts it completely.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_SB, 9'h011, 32'h00000077);
    #1;
    chk("abort granted", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, OP_LW, 9'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmwr_seen = 0;
    @(negedge clk);
    chk("abort rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("abort dm_outputs", {dm_DMWr, dm_addr, dm_LOADSel, dm_byte} | dm_din, 32'd0);
    chk("abort rsp_data", rsp0_rdata | rsp1_rdata | {30'd0, rsp1_err, rsp0_err}, 32'd0);
    drive(1'b0, 1'b1, OP_LW, 9'h010, 32'd0);
    drive(1'b1, 1'b1, OP_LW, 9'h014, 32'd0);
    #1;
    chk("abort tie ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_LW, 9'd0, 32'd0);
    drive(1'b1, 1'b0, OP_LW, 9'd0, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dm_DMWr) dmwr_seen++;
    end
    chk("abort no_write", dmwr_seen, 0);
    chk("abort mem_intact", mem[4], 32'h801155D3);
    chk("abort next rsp0", rsp0_rdata, 32'h801155D3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
